// File: rtl/sub_pkg.sv
// Shared definitions for the sequential borrow subtractor.
package sub_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk widths that evenly tile the datapath as a power of two.
  function automatic bit chunk_legal(input int unsigned c);
    return (c == 1) || (c == 2) || (c == 4) || (c == 8) || (c == 16) || (c == 32);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, borrow out on underflow.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/seq_borrow_subtractor.sv
// Multi-cycle 32-bit subtractor resolving CHUNK bits per clock, LSB chunk first,
// with a registered borrow between chunks and valid/ready on both sides.
// Optional feature macro: SUB_OVF_EN adds the registered signed-overflow output Ovf.
module seq_borrow_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
`ifdef SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             Bout
);

  localparam int unsigned NCHUNK   = WIDTH / CHUNK;
  localparam int unsigned CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CHUNK_LG = $clog2(CHUNK);
  localparam int unsigned OFF_W    = $clog2(WIDTH);

  // Reject chunk widths that do not tile the word.
  if (!chunk_legal(CHUNK)) begin : g_bad_chunk
    $error("seq_borrow_subtractor: illegal CHUNK value %0d", CHUNK);
  end

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, diff_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bw_q, bout_q, in_ready_q, out_valid_q;
`ifdef SUB_OVF_EN
  logic               ovf_q;
`endif

  logic [CHUNK-1:0]   a_chunk, b_chunk, d_chunk;
  logic [CHUNK:0]     bw_chain;
  logic [WIDTH-1:0]   diff_d;
  logic               last_chunk;

  // Select the active chunk and merge its result into the running difference.
  if (NCHUNK == 1) begin : g_single
    assign a_chunk = a_q;
    assign b_chunk = b_q;
    assign diff_d  = d_chunk;
  end else begin : g_multi
    logic [OFF_W-1:0] off;
    assign off     = OFF_W'(32'(cnt_q) << CHUNK_LG);
    assign a_chunk = a_q[off +: CHUNK];
    assign b_chunk = b_q[off +: CHUNK];
    assign diff_d  = (diff_q & ~(WIDTH'({CHUNK{1'b1}}) << off)) | (WIDTH'(d_chunk) << off);
  end

  // Per-cycle borrow chain seeded from the borrow register.
  assign bw_chain[0] = bw_q;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fs
    full_subtractor u_fs (
      .a_i   (a_chunk[i]),
      .b_i   (b_chunk[i]),
      .bin_i (bw_chain[i]),
      .d_o   (d_chunk[i]),
      .bout_o(bw_chain[i+1])
    );
  end

  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  // Control FSM with operand, result, counter and borrow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      bw_q        <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            bw_q       <= Bin;
            cnt_q      <= '0;
            diff_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          diff_q <= diff_d;
          bw_q   <= bw_chain[CHUNK];
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_chunk) begin
            cnt_q       <= '0;
            bout_q      <= bw_chain[CHUNK];
`ifdef SUB_OVF_EN
            ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_chunk[CHUNK-1] != a_q[WIDTH-1]);
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
`ifdef SUB_OVF_EN
  assign Ovf       = ovf_q;
`endif

endmodule
